lifo_stack_param: RTL and testbench

- Parametrised LIFO stack. Next generation of the team's fixed 16-bit, 8-deep stack.
- Adds the following over that stack:
  - configurable WIDTH and DEPTH;
  - an atomic replace-top operation (push and pop in the same cycle);
  - an occupancy count and an almost-full flag;
  - sticky overflow/underflow error flags;
  - a valid strobe on the output, instead of driving Z.
- Sits between a producer and consumer of operand/return-address style data in the data-storage library.

---
 rtl/lifo_pkg.sv | 21 ++
 rtl/lifo_mem_sp.sv | 36 +++
 rtl/lifo_stack_param.sv | 135 +++++++++++++
 tb/tb_lifo_stack_param.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/lifo_pkg.sv
// Shared definitions for the parametrised LIFO stack.
//   lifo_op_t   - one-hot-free operation code produced by the per-cycle decode
//   count_width - number of bits needed to hold an occupancy of 0..depth
package lifo_pkg;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_PEEK,
    OP_REPLACE,
    OP_OVF,
    OP_UNF
  } lifo_op_t;

  // Occupancy runs 0..depth inclusive, so it needs one more code than depth.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/lifo_mem_sp.sv
// Storage array for the LIFO stack.
// Ports:
//   clk   - write clock
//   we    - write enable
//   waddr - write index
//   wdata - write data
//   raddr - read index (asynchronous read)
//   rdata - read data; zero when raddr is outside the array
module lifo_mem_sp #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // With a non power-of-two depth the index space is larger than the array;
  // the out-of-range codes (only seen when the stack is empty) read as zero
  // so nothing undefined can reach the output register.
  always_comb begin
    rdata = '0;
    if (int'(raddr) < DEPTH) rdata = mem[raddr];
  end

endmodule

// File: rtl/lifo_stack_param.sv
// Parametrised LIFO stack with replace-top, occupancy count, almost-full flag
// and sticky overflow/underflow error flags.
// Ports:
//   Clk_In, Reset_In      - clock and synchronous active-high reset
//   Data_In               - word to push
//   Push_In, Pop_In       - push / pop requests (both together = replace top)
//   Peek_In               - read top without removing it (ignored with push/pop)
//   Clear_Err_In          - clears the sticky error flags (a new error wins)
//   Data_Out              - registered read data, holds between reads
//   Data_Valid_Out        - one-cycle strobe, Data_Out was updated this cycle
//   LIFO_Count            - current occupancy
//   LIFO_Empty/Full/Almost_Full - status derived from LIFO_Count
//   Overflow_Err          - sticky: a push was dropped
//   Underflow_Err         - sticky: pop or peek on an empty stack
//
// Handshake: there is no back-pressure. Every request is acted on in the cycle
// it is presented; requests that cannot be honoured are dropped and recorded
// in the sticky error flags. Data_Valid_Out qualifies Data_Out for exactly one
// cycle, one cycle after the request.
module lifo_stack_param
  import lifo_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 1
) (
  input  logic                                Clk_In,
  input  logic                                Reset_In,
  input  logic [WIDTH-1:0]                    Data_In,
  input  logic                                Push_In,
  input  logic                                Pop_In,
  input  logic                                Peek_In,
  input  logic                                Clear_Err_In,
  output logic [WIDTH-1:0]                    Data_Out,
  output logic                                Data_Valid_Out,
  output logic [lifo_pkg::count_width(DEPTH)-1:0] LIFO_Count,
  output logic                                LIFO_Empty,
  output logic                                LIFO_Full,
  output logic                                LIFO_Almost_Full,
  output logic                                Overflow_Err,
  output logic                                Underflow_Err
);

  localparam int CW = count_width(DEPTH);
  localparam int AW = $clog2(DEPTH);

  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  lifo_op_t         op;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    push_idx;
  logic [AW-1:0]    waddr;
  logic             we;
  logic [WIDTH-1:0] top_data;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // top_idx is only consumed when the stack is non-empty and push_idx only
  // when it is not full, so the truncations below never select a wrapped slot.
  assign top_idx  = AW'(count - CW'(1));
  assign push_idx = AW'(count);

  // Per-cycle decode in priority order. Push with pop on an empty stack falls
  // into the push branch; an empty stack is never full because DEPTH >= 2.
  always_comb begin
    op = OP_IDLE;
    if (Push_In && Pop_In && !empty) begin
      op = OP_REPLACE;
    end else if (Push_In) begin
      op = full ? OP_OVF : OP_PUSH;
    end else if (Pop_In) begin
      op = empty ? OP_UNF : OP_POP;
    end else if (Peek_In) begin
      op = empty ? OP_UNF : OP_PEEK;
    end
  end

  // Reset must also suppress the array write so a reset cycle changes nothing
  // but the registers it clears.
  assign we    = !Reset_In && ((op == OP_PUSH) || (op == OP_REPLACE));
  assign waddr = (op == OP_REPLACE) ? top_idx : push_idx;

  lifo_mem_sp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (Clk_In),
    .we    (we),
    .waddr (waddr),
    .wdata (Data_In),
    .raddr (top_idx),
    .rdata (top_data)
  );

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      count          <= '0;
      Data_Out       <= '0;
      Data_Valid_Out <= 1'b0;
      Overflow_Err   <= 1'b0;
      Underflow_Err  <= 1'b0;
    end else begin
      Data_Valid_Out <= 1'b0;
      if (Clear_Err_In) begin
        Overflow_Err  <= 1'b0;
        Underflow_Err <= 1'b0;
      end
      // Error sets come after the clear so a simultaneous new error wins.
      case (op)
        OP_PUSH: count <= count + CW'(1);
        OP_POP: begin
          Data_Out       <= top_data;
          Data_Valid_Out <= 1'b1;
          count          <= count - CW'(1);
        end
        OP_PEEK, OP_REPLACE: begin
          Data_Out       <= top_data;
          Data_Valid_Out <= 1'b1;
        end
        OP_OVF:  Overflow_Err  <= 1'b1;
        OP_UNF:  Underflow_Err <= 1'b1;
        default: ;
      endcase
    end
  end

  assign LIFO_Count       = count;
  assign LIFO_Empty       = empty;
  assign LIFO_Full        = full;
  assign LIFO_Almost_Full = (count >= CW'(AF_THRESH));

endmodule

// File: tb/tb_lifo_stack_param.sv
module tb_lifo_stack_param;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int AF    = 7;

  // ---------------- clock / reset / DUT ----------------
  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic             push, pop, peek, clr;
  logic [WIDTH-1:0] dout;
  logic             dvalid;
  logic [3:0]       count;
  logic             empty, full, afull, ovf, unf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  lifo_stack_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF)) dut (
    .Clk_In           (clk),
    .Reset_In         (rst),
    .Data_In          (din),
    .Push_In          (push),
    .Pop_In           (pop),
    .Peek_In          (peek),
    .Clear_Err_In     (clr),
    .Data_Out         (dout),
    .Data_Valid_Out   (dvalid),
    .LIFO_Count       (count),
    .LIFO_Empty       (empty),
    .LIFO_Full        (full),
    .LIFO_Almost_Full (afull),
    .Overflow_Err     (ovf),
    .Underflow_Err    (unf)
  );

  // ---------------- scoreboard / model ----------------
  logic [WIDTH-1:0] exp_q[$];   // model stack contents, back = top
  logic [WIDTH-1:0] m_dout;
  logic             m_valid, m_ovf, m_unf;
  logic             check_en;
  int               n_vec;
  int               n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Stack semantics applied to the queue model at each active edge.
  task automatic model_edge(input logic r, input logic pu, input logic po,
                            input logic pk, input logic cl, input logic [WIDTH-1:0] d);
    if (r) begin
      exp_q.delete();
      m_dout = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      return;
    end
    m_valid = 1'b0;
    if (cl) begin m_ovf = 1'b0; m_unf = 1'b0; end
    if (pu && po && exp_q.size() > 0) begin
      m_dout = exp_q[$];
      exp_q[exp_q.size()-1] = d;
      m_valid = 1'b1;
    end else if (pu) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else m_ovf = 1'b1;
    end else if (po) begin
      if (exp_q.size() > 0) begin m_dout = exp_q.pop_back(); m_valid = 1'b1; end
      else m_unf = 1'b1;
    end else if (pk) begin
      if (exp_q.size() > 0) begin m_dout = exp_q[$]; m_valid = 1'b1; end
      else m_unf = 1'b1;
    end
  endtask

  // Every cycle after the first reset: all outputs against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("count",  32'(count),  32'(exp_q.size()));
      chk("empty",  32'(empty),  32'(exp_q.size() == 0));
      chk("full",   32'(full),   32'(exp_q.size() == DEPTH));
      chk("afull",  32'(afull),  32'(exp_q.size() >= AF));
      chk("valid",  32'(dvalid), 32'(m_valid));
      chk("dout",   32'(dout),   32'(m_dout));
      chk("ovf",    32'(ovf),    32'(m_ovf));
      chk("unf",    32'(unf),    32'(m_unf));
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic pu, input logic po, input logic pk,
                      input logic cl, input logic [WIDTH-1:0] d);
    rst = r; push = pu; pop = po; peek = pk; clr = cl; din = d;
    @(posedge clk);
    model_edge(r, pu, po, pk, cl, d);
    @(negedge clk);
    rst = 1'b0; push = 1'b0; pop = 1'b0; peek = 1'b0; clr = 1'b0; din = '0;
  endtask

  task automatic do_push(input logic [WIDTH-1:0] d); step(0, 1, 0, 0, 0, d); endtask
  task automatic do_pop();                          step(0, 0, 1, 0, 0, '0); endtask
  task automatic do_peek();                         step(0, 0, 0, 1, 0, '0); endtask
  task automatic do_clear();                        step(0, 0, 0, 0, 1, '0); endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_vec = 0; n_fail = 0; check_en = 1'b0;
    m_dout = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    rst = 1'b0; push = 1'b0; pop = 1'b0; peek = 1'b0; clr = 1'b0; din = '0;

    @(negedge clk);
    step(1, 0, 0, 0, 0, '0);
    check_en = 1'b1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_dout",  32'(dout),  32'h0);
    chk("rst_empty", 32'(empty), 32'd1);

    // Basic push / pop ordering.
    do_push(16'h1111); do_push(16'h2222); do_push(16'h3333);
    chk("cnt3", 32'(count), 32'd3);
    do_pop(); chk("pop1", 32'(dout), 32'h3333); chk("pop1_v", 32'(dvalid), 32'd1);
    do_pop(); chk("pop2", 32'(dout), 32'h2222); chk("pop2_v", 32'(dvalid), 32'd1);
    do_pop(); chk("pop3", 32'(dout), 32'h1111); chk("pop3_v", 32'(dvalid), 32'd1);
    chk("empty_after", 32'(empty), 32'd1);

    // Fill, almost-full, full, overflow.
    for (int i = 0; i < 8; i++) begin
      do_push(16'hA000 + 16'(i));
      if (i == 6) begin
        chk("af_at7",   32'(afull), 32'd1);
        chk("full_at7", 32'(full),  32'd0);
      end
      if (i == 5) chk("af_at6", 32'(afull), 32'd0);
    end
    chk("full_at8", 32'(full), 32'd1);
    do_push(16'hBEEF);
    chk("ovf_set",  32'(ovf),   32'd1);
    chk("ovf_cnt",  32'(count), 32'd8);
    do_pop();
    chk("pop_a007", 32'(dout), 32'hA007);
    chk("ovf_sticky", 32'(ovf), 32'd1);
    do_clear();
    chk("ovf_clr", 32'(ovf), 32'd0);
    for (int i = 0; i < 7; i++) do_pop();
    chk("drained", 32'(count), 32'd0);

    // Underflow, clear, and set-wins-over-clear.
    do_pop();
    chk("unf_set",   32'(unf),    32'd1);
    chk("unf_valid", 32'(dvalid), 32'd0);
    chk("unf_cnt",   32'(count),  32'd0);
    do_clear();
    chk("unf_clr", 32'(unf), 32'd0);
    step(0, 0, 1, 0, 1, '0);
    chk("unf_wins", 32'(unf), 32'd1);
    do_peek();
    chk("peek_empty_v", 32'(dvalid), 32'd0);
    do_clear();

    // Replace top, then replace when full.
    do_push(16'h0005);
    step(0, 1, 1, 0, 0, 16'h00AA);
    chk("rep_dout", 32'(dout),   32'h0005);
    chk("rep_cnt",  32'(count),  32'd1);
    chk("rep_v",    32'(dvalid), 32'd1);
    do_peek();
    chk("rep_peek", 32'(dout), 32'h00AA);
    for (int i = 0; i < 7; i++) do_push(16'hC000 + 16'(i));
    chk("full_again", 32'(full), 32'd1);
    step(0, 1, 1, 0, 0, 16'h0055);
    chk("repf_dout", 32'(dout),  32'hC006);
    chk("repf_ovf",  32'(ovf),   32'd0);
    chk("repf_cnt",  32'(count), 32'd8);
    do_peek();
    chk("repf_peek", 32'(dout), 32'h0055);
    // Peek combined with pop acts as a plain pop.
    step(0, 0, 1, 1, 0, '0);
    chk("peekpop_cnt", 32'(count), 32'd7);

    // Peek twice, then push+pop on empty.
    step(1, 0, 0, 0, 0, '0);
    do_push(16'h0FFF); do_push(16'h1234);
    do_peek();
    chk("pk1", 32'(dout), 32'h1234); chk("pk1_cnt", 32'(count), 32'd2);
    do_peek();
    chk("pk2", 32'(dout), 32'h1234); chk("pk2_cnt", 32'(count), 32'd2);
    do_pop(); do_pop();
    step(0, 1, 1, 0, 0, 16'h0042);
    chk("pp_empty_cnt", 32'(count), 32'd1);
    chk("pp_empty_unf", 32'(unf),   32'd0);
    chk("pp_empty_ovf", 32'(ovf),   32'd0);
    do_pop();
    chk("pp_empty_data", 32'(dout), 32'h0042);

    // Reset overrides a push mid-operation.
    do_pop();   // leaves Underflow_Err set
    for (int i = 0; i < 5; i++) do_push(16'hD000 + 16'(i));
    chk("cnt5", 32'(count), 32'd5);
    step(1, 1, 0, 0, 0, 16'hFFFF);
    chk("mrst_cnt",   32'(count), 32'd0);
    chk("mrst_dout",  32'(dout),  32'h0);
    chk("mrst_unf",   32'(unf),   32'd0);
    chk("mrst_ovf",   32'(ovf),   32'd0);
    chk("mrst_empty", 32'(empty), 32'd1);
    do_push(16'h7777);
    do_pop();
    chk("post_rst", 32'(dout), 32'h7777);

    check_en = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
